data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the core's data-memory port. Single-port word array with byte-lane writes and
//  a multi-cycle read handshake: read_enable level-held by the core; exactly one read_valid pulse
//  per load. Aligns byte/half data to addr[1:0]. Sits between the pipeline MEM stage and local RAM.
// PARAMETERS
//  DEPTH_WORDS   4096    array depth in 32-bit words (power of 2)
//  READ_LATENCY  2       cycles from request acceptance to read_valid (>=1)
//  BASE_ADDR     32'h0   byte address of word 0 (word-aligned)
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous, active-high reset
//  address       in   32  byte address (held stable by core while load stalled)
//  write_data    in   32  store data, low-aligned (byte in [7:0], half in [15:0])
//  write_enable  in   1   store strobe, single cycle, no handshake
//  write_mask    in   4   low-aligned lanes: 0001 SB, 0011 SH, 1111 SW
//  read_enable   in   1   load request, level, held until read_valid cycle inclusive
//  read_data     out  32  load data, right-aligned by addr[1:0] (core sign/zero-extends)
//  read_valid    out  1   one-cycle pulse: read_data valid this cycle
//  busy          out  1   high in BUSY and VALID states
//  err           out  1   sticky: out-of-range access or lane overflow
// BEHAVIOUR
//  Reset: state=IDLE, read_valid=0, read_data=0, busy=0, err=0, latency counter=0;
//   array contents not reset. rst mid-read abandons request: no read_valid afterward.
//  Word index = (address-BASE_ADDR)>>2; in range iff BASE_ADDR <= address < BASE_ADDR+4*DEPTH_WORDS.
//  Store: at posedge with write_enable=1, in any state: lanes = write_mask<<addr[1:0],
//   data = write_data<<(8*addr[1:0]); lanes shifted past bit 3 dropped and err<=1.
//   Out-of-range store: dropped, err<=1.
//  FSM states IDLE, BUSY, VALID:
//   IDLE: read_enable=1 at cycle T -> accept: snapshot word (write-first: same-cycle store merged
//    byte-wise), latch addr[1:0] and range flag; go BUSY with cnt=READ_LATENCY-1;
//    if READ_LATENCY==1 go VALID directly.
//   BUSY: decrement cnt; at cnt==1 -> VALID. read_enable/address ignored. Stores to the snapshot
//    word do NOT alter returned data.
//   VALID (cycle T+READ_LATENCY): read_valid=1, read_data=snapshot>>(8*addr_lo).
//    -> IDLE unconditionally; read_enable seen in the following IDLE cycle is a NEW load.
//  read_valid=0 outside VALID; read_data holds last returned value outside VALID.
//  Out-of-range load: handshake timing unchanged, read_data=0, err<=1.
//  Load with addr[1:0]!=0 needs no error; upper bytes zero-filled by the shift.
//  read_enable dropped during BUSY (illegal): request completes normally regardless.
//  err clears only on rst.
// TESTING
//  1 SW 0xDEADBEEF @0x10 mask 1111; LW 0x10 (LAT=2) req at T -> read_valid only at T+2, data 0xDEADBEEF.
//  2 SB 0xAB @0x13 mask 0001 -> word 0x10=0xABADBEEF; LB 0x13 -> read_data=0x000000AB, err=0.
//  3 read_enable held across two loads 0x10 then 0x14 (0x11223344) -> pulses at T+2 and T+5, correct data each.
//  4 Load 0x10 accepted; SW 0x55555555 @0x10 during BUSY -> returns 0xABADBEEF; same-cycle SW+LW -> new data.
//  5 LW 0xFFFF0000 -> read_valid at T+2, data 0, err=1 and stays 1; SH @0x13 -> err=1, lane 0x10[31:24] only written.
//  6 rst asserted in BUSY -> no read_valid, busy=0 next cycle; next LW 0x10 completes normally at T'+2.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Core-to-RAM data-memory bus: store strobe, level-held load request, single-pulse load response.
interface data_mem_responder_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [3:0]  write_mask;
  logic        read_enable;
  logic [31:0] read_data;
  logic        read_valid;
  logic        busy;
  logic        err;

  modport master (
    output address, write_data, write_enable, write_mask, read_enable,
    input  read_data, read_valid, busy, err
  );

  modport slave (
    input  address, write_data, write_enable, write_mask, read_enable,
    output read_data, read_valid, busy, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory port: byte-lane word RAM with a fixed-latency read handshake.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned LP_IW   = $clog2(DEPTH_WORDS);
  localparam int unsigned LP_CW   = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
  localparam logic [32:0] LP_SPAN = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_VALID} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LP_CW-1:0] r_cnt;
  logic [LP_CW-1:0] w_cnt_nxt;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_snap;
  logic [1:0]       r_addr_lo;
  logic             r_in_range;
  logic [31:0]      r_read_data;
  logic             r_read_valid;
  logic             r_busy;
  logic             r_err;

  logic [31:0]      w_offset;
  logic             w_in_range;
  logic [LP_IW-1:0] w_index;
  logic [1:0]       w_addr_lo;
  logic [7:0]       w_lanes_wide;
  logic [3:0]       w_lanes;
  logic             w_lane_ovf;
  logic [31:0]      w_wdata_sh;
  logic             w_store;
  logic             w_accept;
  logic [31:0]      w_snap_now;
  logic [31:0]      w_sel_snap;
  logic [1:0]       w_sel_lo;
  logic             w_sel_range;
  logic [31:0]      w_rdata_nxt;
  logic             w_unused_ok;

  // Address decode and lane/data alignment shared by store and load paths
  assign w_offset     = bus.address - BASE_ADDR;
  assign w_in_range   = (bus.address >= BASE_ADDR) && ({1'b0, w_offset} < LP_SPAN);
  assign w_index      = w_offset[LP_IW+1:2];
  assign w_addr_lo    = bus.address[1:0];
  assign w_lanes_wide = {4'b0000, bus.write_mask} << w_addr_lo;
  assign w_lanes      = w_lanes_wide[3:0];
  assign w_lane_ovf   = |w_lanes_wide[7:4];
  assign w_wdata_sh   = bus.write_data << {w_addr_lo, 3'b000};
  assign w_store      = bus.write_enable && w_in_range;
  assign w_accept     = (r_state == S_IDLE) && bus.read_enable;
  assign w_unused_ok  = ^w_offset;

  // Write-first snapshot: a same-cycle store to the requested word wins per byte lane
  always_comb begin
    w_snap_now = r_mem[w_index];
    for (int i = 0; i < 4; i++) begin
      if (w_store && w_lanes[i]) begin
        w_snap_now[8*i +: 8] = w_wdata_sh[8*i +: 8];
      end
    end
  end

  // Return data: live snapshot when going straight from IDLE to VALID, latched one otherwise
  assign w_sel_snap  = (r_state == S_IDLE) ? w_snap_now : r_snap;
  assign w_sel_lo    = (r_state == S_IDLE) ? w_addr_lo  : r_addr_lo;
  assign w_sel_range = (r_state == S_IDLE) ? w_in_range : r_in_range;
  assign w_rdata_nxt = w_sel_range ? (w_sel_snap >> {w_sel_lo, 3'b000}) : 32'h0;

  // Next-state logic for the read handshake
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.read_enable) begin
          if (READ_LATENCY == 1) begin
            w_state_nxt = S_VALID;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = LP_CW'(READ_LATENCY - 1);
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == LP_CW'(1)) begin
          w_state_nxt = S_VALID;
        end else begin
          w_cnt_nxt = r_cnt - LP_CW'(1);
        end
      end
      S_VALID: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_snap       <= 32'h0;
      r_addr_lo    <= 2'b00;
      r_in_range   <= 1'b0;
      r_read_data  <= 32'h0;
      r_read_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_read_valid <= (w_state_nxt == S_VALID);
      r_busy       <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_snap     <= w_snap_now;
        r_addr_lo  <= w_addr_lo;
        r_in_range <= w_in_range;
      end
      if (w_state_nxt == S_VALID) begin
        r_read_data <= w_rdata_nxt;
      end
      if ((bus.write_enable && (!w_in_range || w_lane_ovf)) || (w_accept && !w_in_range)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Byte-lane RAM write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes[i]) begin
          r_mem[w_index][8*i +: 8] <= w_wdata_sh[8*i +: 8];
        end
      end
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.read_valid = r_read_valid;
  assign bus.busy       = r_busy;
  assign bus.err        = r_err;

endmodule
